regfile: RTL and testbench
==========================

# regfile

General-purpose register file at the receiving end of the MEM/WB write-back interface. Accepts one write per cycle from the write-back stage and serves two combinational read ports to the decode stage. Resolves RAW hazards by forwarding from EX, MEM and WB results, and flags load-use hazards for the pipeline control unit. x0 is hardwired to zero.

## Interface
- XLEN, 64, register data width (matches RegBus)
- AW, 5, register address width (matches RegAddrBus); depth = 2**AW

- clk  in  1  system clock; all state updates on rising edge
- rst_n  in  1  reset; asynchronous, active-low
- wb_wd  in  AW  write-back destination register
- wb_wreg  in  1  write-back enable
- wb_wdata  in  XLEN  write-back data
- re1 / re2  in  1  read-port enables
- raddr1 / raddr2  in  AW  read addresses
- rdata1 / rdata2  out  XLEN  read data (combinational)
- ex_wreg, ex_wd, ex_wdata  in  1/AW/XLEN  EX-stage result, forwarding source
- ex_is_load  in  1  EX-stage instruction is a load; ex_wdata not yet valid
- mem_wreg, mem_wd, mem_wdata  in  1/AW/XLEN  MEM-stage result, forwarding source
- load_use_stall  out  1  decode must stall one cycle (combinational)

## Operation
- Storage: 2**AW - 1 registers of XLEN bits (x1..x31). x0 has no storage and always reads 0.
- Write: on a rising clk with rst_n=1 and wb_wreg=1 and wb_wd!=0, reg[wb_wd] <= wb_wdata. A write to x0 is silently dropped.
- Read port n, evaluated in priority order. The first matching rule wins:
  - re_n=0 -> 0
  - raddr_n=0 -> 0
  - ex_wreg=1, ex_is_load=0, ex_wd==raddr_n -> ex_wdata
  - mem_wreg=1, mem_wd==raddr_n -> mem_wdata
  - wb_wreg=1, wb_wd==raddr_n -> wb_wdata (write-through bypass)
  - otherwise -> reg[raddr_n]
- Match against a source requires that source's wd != 0. Forwarding of x0 is never allowed.
- load_use_stall = ex_wreg & ex_is_load & (ex_wd!=0) & ((re1 & raddr1==ex_wd) | (re2 & raddr2==ex_wd)).
  - While the stall is asserted, that port does not take the EX value. It falls through to MEM/WB/array. Decode must ignore the data.
- Both ports are fully independent. Identical addresses on both ports return identical data.

## Timing
- Write latency: 1 cycle into the array. The value is visible the same cycle through the WB bypass, and from the array on the next cycle.
- Read latency: 0 cycles. rdata and load_use_stall are purely combinational from inputs and array state.
- Reset: rst_n low immediately clears all registers to 0, asynchronously, without waiting for clk. While rst_n=0:
  - rdata1 = rdata2 = 0
  - load_use_stall = 0
  - writes are ignored
- Reset deassertion is synchronised upstream. The first write can occur on the first clk edge with rst_n=1.
- Reset mid-operation: any pending write on that edge is lost and the array reads 0 afterwards.
- Simultaneous events:
  - EX, MEM and WB all targeting the same register -> the EX value wins.
  - A WB write and a read of the same register in one cycle -> the read returns wb_wdata.

## Test plan
- Reset: write x5=0x1234, pulse rst_n low mid-cycle with no clk edge -> rdata1 for raddr1=5 reads 0 immediately; after release, still 0.
- Write/read: wb_wreg=1, wb_wd=10, wb_wdata=0xDEAD_BEEF_0000_0001. Same cycle raddr1=10 -> rdata1=0xDEADBEEF00000001 (bypass). Next cycle with wb_wreg=0 -> same value from the array.
- x0: wb write x0=0xFFFF; ex_wd=0, ex_wreg=1, ex_wdata=7 -> reading raddr1=0 returns 0 and raddr2=0 returns 0.
- Priority: x3 array=1, wb x3=2, mem x3=3, ex x3=4 -> rdata=4. Drop ex -> 3. Drop mem -> 2. Drop wb -> 1.
- Load-use: ex_is_load=1, ex_wreg=1, ex_wd=8, re2=1, raddr2=8 -> load_use_stall=1 and rdata2 comes from MEM/WB/array. With re2=0 -> stall=0. With ex_wd=0 -> stall=0.
- Enables: re1=0 with raddr1=3 holding 0x55 -> rdata1=0. re2=1 on the same address -> rdata2=0x55.

Source files
------------

// File: rtl/regfile.sv
// Integer register file with a write-back port, two combinational read ports,
// EX/MEM/WB forwarding and load-use hazard detection. x0 always reads zero.
module regfile #(
  parameter int XLEN = 64,
  parameter int AW   = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [AW-1:0]   wb_wd,
  input  logic            wb_wreg,
  input  logic [XLEN-1:0] wb_wdata,
  input  logic            re1,
  input  logic            re2,
  input  logic [AW-1:0]   raddr1,
  input  logic [AW-1:0]   raddr2,
  output logic [XLEN-1:0] rdata1,
  output logic [XLEN-1:0] rdata2,
  input  logic            ex_wreg,
  input  logic [AW-1:0]   ex_wd,
  input  logic [XLEN-1:0] ex_wdata,
  input  logic            ex_is_load,
  input  logic            mem_wreg,
  input  logic [AW-1:0]   mem_wd,
  input  logic [XLEN-1:0] mem_wdata,
  output logic            load_use_stall
);

  localparam int DEPTH = 2 ** AW;

  // Entry 0 is never written, so it stays a constant zero after reset.
  logic [XLEN-1:0] regs_r [DEPTH];
  logic [XLEN-1:0] rdata1_s;
  logic [XLEN-1:0] rdata2_s;
  logic            stall_s;

  // Array write from the write-back stage; asynchronous clear on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_r[i] <= {XLEN{1'b0}};
      end
    end else if (wb_wreg && (wb_wd != {AW{1'b0}})) begin
      regs_r[wb_wd] <= wb_wdata;
    end else begin
      regs_r <= regs_r;
    end
  end

  function automatic logic [XLEN-1:0] read_sel(
    input logic            re,
    input logic [AW-1:0]   ra,
    input logic [XLEN-1:0] arr
  );
    logic [XLEN-1:0] res;
    if (!re || (ra == {AW{1'b0}})) begin
      res = {XLEN{1'b0}};
    end else if (ex_wreg && !ex_is_load && (ex_wd != {AW{1'b0}}) && (ex_wd == ra)) begin
      res = ex_wdata;
    end else if (mem_wreg && (mem_wd != {AW{1'b0}}) && (mem_wd == ra)) begin
      res = mem_wdata;
    end else if (wb_wreg && (wb_wd != {AW{1'b0}}) && (wb_wd == ra)) begin
      res = wb_wdata;
    end else begin
      res = arr;
    end
    return res;
  endfunction

  // Read muxes and hazard detect; everything is forced quiet while in reset.
  always_comb begin
    rdata1_s = {XLEN{1'b0}};
    rdata2_s = {XLEN{1'b0}};
    stall_s  = 1'b0;
    if (rst_n) begin
      rdata1_s = read_sel(re1, raddr1, regs_r[raddr1]);
      rdata2_s = read_sel(re2, raddr2, regs_r[raddr2]);
      stall_s  = ex_wreg && ex_is_load && (ex_wd != {AW{1'b0}}) &&
                 ((re1 && (raddr1 == ex_wd)) || (re2 && (raddr2 == ex_wd)));
    end else begin
      rdata1_s = {XLEN{1'b0}};
      rdata2_s = {XLEN{1'b0}};
      stall_s  = 1'b0;
    end
  end

  assign rdata1         = rdata1_s;
  assign rdata2         = rdata2_s;
  assign load_use_stall = stall_s;

endmodule

// File: tb/tb_regfile.sv
// Directed bench for regfile: stimulus pushes expected read results into a
// queue; a monitor pops and compares each time a sample is presented.
`timescale 1ns/1ps
module tb_regfile;
  localparam int XLEN = 64;
  localparam int AW   = 5;

  logic            clk;
  logic            rst_n;
  logic [AW-1:0]   wb_wd;
  logic            wb_wreg;
  logic [XLEN-1:0] wb_wdata;
  logic            re1, re2;
  logic [AW-1:0]   raddr1, raddr2;
  logic [XLEN-1:0] rdata1, rdata2;
  logic            ex_wreg;
  logic [AW-1:0]   ex_wd;
  logic [XLEN-1:0] ex_wdata;
  logic            ex_is_load;
  logic            mem_wreg;
  logic [AW-1:0]   mem_wd;
  logic [XLEN-1:0] mem_wdata;
  logic            load_use_stall;

  regfile #(.XLEN(XLEN), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .wb_wd(wb_wd), .wb_wreg(wb_wreg), .wb_wdata(wb_wdata),
    .re1(re1), .re2(re2), .raddr1(raddr1), .raddr2(raddr2),
    .rdata1(rdata1), .rdata2(rdata2),
    .ex_wreg(ex_wreg), .ex_wd(ex_wd), .ex_wdata(ex_wdata), .ex_is_load(ex_is_load),
    .mem_wreg(mem_wreg), .mem_wd(mem_wd), .mem_wdata(mem_wdata),
    .load_use_stall(load_use_stall)
  );

  // 40 ns period: each low phase leaves room for several combinational samples.
  initial clk = 1'b0;
  always #20 clk = ~clk;

  typedef struct {
    string           name;
    logic [XLEN-1:0] e1;
    logic [XLEN-1:0] e2;
    logic            es;
  } exp_t;

  exp_t exp_q[$];
  event sample_ev;
  int   total = 0;
  int   bad   = 0;
  int   popped = 0;

  // Monitor: one expectation is consumed per presented sample.
  initial begin
    forever begin
      @(sample_ev);
      #1;
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL scoreboard_underflow: sample with no expectation");
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        popped++;
        total++;
        if (rdata1 !== e.e1) begin
          bad++;
          $display("FAIL %s rdata1: got %h want %h", e.name, rdata1, e.e1);
        end
        total++;
        if (rdata2 !== e.e2) begin
          bad++;
          $display("FAIL %s rdata2: got %h want %h", e.name, rdata2, e.e2);
        end
        total++;
        if (load_use_stall !== e.es) begin
          bad++;
          $display("FAIL %s stall: got %b want %b", e.name, load_use_stall, e.es);
        end
      end
    end
  end

  task automatic expect_now(input string name, input logic [XLEN-1:0] e1,
                            input logic [XLEN-1:0] e2, input logic es);
    exp_t e;
    e.name = name; e.e1 = e1; e.e2 = e2; e.es = es;
    exp_q.push_back(e);
    -> sample_ev;
    #2;
  endtask

  task automatic idle_inputs();
    wb_wreg = 1'b0; wb_wd = '0; wb_wdata = '0;
    ex_wreg = 1'b0; ex_wd = '0; ex_wdata = '0; ex_is_load = 1'b0;
    mem_wreg = 1'b0; mem_wd = '0; mem_wdata = '0;
    re1 = 1'b0; re2 = 1'b0; raddr1 = '0; raddr2 = '0;
  endtask

  // Write one register through the WB port across a single rising edge.
  task automatic wb_write(input logic [AW-1:0] a, input logic [XLEN-1:0] d);
    @(negedge clk);
    wb_wreg = 1'b1; wb_wd = a; wb_wdata = d;
    @(negedge clk);
    wb_wreg = 1'b0; wb_wd = '0; wb_wdata = '0;
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    #3;
    // In reset, a matching EX load and an EX forward must not leak out.
    re1 = 1'b1; raddr1 = 5'd5; re2 = 1'b1; raddr2 = 5'd5;
    ex_wreg = 1'b1; ex_wd = 5'd5; ex_wdata = 64'h99; ex_is_load = 1'b1;
    expect_now("reset_quiet", 64'h0, 64'h0, 1'b0);
    ex_is_load = 1'b0;
    expect_now("reset_no_fwd", 64'h0, 64'h0, 1'b0);
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;

    // Asynchronous reset between clock edges clears the array.
    wb_write(5'd5, 64'h1234);
    re1 = 1'b1; raddr1 = 5'd5;
    expect_now("x5_written", 64'h1234, 64'h0, 1'b0);
    rst_n = 1'b0;
    expect_now("x5_async_rst", 64'h0, 64'h0, 1'b0);
    rst_n = 1'b1;
    expect_now("x5_after_rst", 64'h0, 64'h0, 1'b0);

    // Write-through bypass, then the same value from the array.
    @(negedge clk);
    wb_wreg = 1'b1; wb_wd = 5'd10; wb_wdata = 64'hDEAD_BEEF_0000_0001;
    re1 = 1'b1; raddr1 = 5'd10; re2 = 1'b1; raddr2 = 5'd10;
    expect_now("wb_bypass", 64'hDEAD_BEEF_0000_0001, 64'hDEAD_BEEF_0000_0001, 1'b0);
    @(negedge clk);
    wb_wreg = 1'b0; wb_wd = '0; wb_wdata = '0;
    expect_now("array_read", 64'hDEAD_BEEF_0000_0001, 64'hDEAD_BEEF_0000_0001, 1'b0);

    // x0 never forwards and never stores.
    @(negedge clk);
    wb_wreg = 1'b1; wb_wd = 5'd0; wb_wdata = 64'hFFFF;
    ex_wreg = 1'b1; ex_wd = 5'd0; ex_wdata = 64'h7;
    mem_wreg = 1'b1; mem_wd = 5'd0; mem_wdata = 64'h9;
    raddr1 = 5'd0; raddr2 = 5'd0;
    expect_now("x0_fwd", 64'h0, 64'h0, 1'b0);
    @(negedge clk);
    idle_inputs();
    re1 = 1'b1; re2 = 1'b1;
    expect_now("x0_array", 64'h0, 64'h0, 1'b0);

    // Forwarding priority EX > MEM > WB > array.
    wb_write(5'd3, 64'h1);
    re1 = 1'b1; raddr1 = 5'd3; re2 = 1'b1; raddr2 = 5'd10;
    wb_wreg = 1'b1; wb_wd = 5'd3; wb_wdata = 64'h2;
    mem_wreg = 1'b1; mem_wd = 5'd3; mem_wdata = 64'h3;
    ex_wreg = 1'b1; ex_wd = 5'd3; ex_wdata = 64'h4;
    expect_now("prio_ex", 64'h4, 64'hDEAD_BEEF_0000_0001, 1'b0);
    ex_wreg = 1'b0;
    expect_now("prio_mem", 64'h3, 64'hDEAD_BEEF_0000_0001, 1'b0);
    mem_wreg = 1'b0;
    expect_now("prio_wb", 64'h2, 64'hDEAD_BEEF_0000_0001, 1'b0);
    wb_wreg = 1'b0;
    expect_now("prio_array", 64'h1, 64'hDEAD_BEEF_0000_0001, 1'b0);
    idle_inputs();

    // Load-use hazard detection and fall-through of the stalled port.
    wb_write(5'd8, 64'h88);
    ex_wreg = 1'b1; ex_is_load = 1'b1; ex_wd = 5'd8; ex_wdata = 64'hBAD;
    mem_wreg = 1'b1; mem_wd = 5'd8; mem_wdata = 64'h800;
    re2 = 1'b1; raddr2 = 5'd8;
    expect_now("lu_mem", 64'h0, 64'h800, 1'b1);
    mem_wreg = 1'b0;
    expect_now("lu_array", 64'h0, 64'h88, 1'b1);
    re2 = 1'b0;
    expect_now("lu_re2_off", 64'h0, 64'h0, 1'b0);
    re1 = 1'b1; raddr1 = 5'd8;
    expect_now("lu_port1", 64'h88, 64'h0, 1'b1);
    @(negedge clk);
    re1 = 1'b0; re2 = 1'b1; ex_wd = 5'd0;
    expect_now("lu_x0", 64'h0, 64'h88, 1'b0);
    ex_wd = 5'd8; ex_is_load = 1'b0;
    expect_now("ex_fwd_nonload", 64'h0, 64'hBAD, 1'b0);
    idle_inputs();

    // Read enables and independent ports.
    wb_write(5'd3, 64'h55);
    re1 = 1'b0; raddr1 = 5'd3; re2 = 1'b1; raddr2 = 5'd3;
    expect_now("re1_off", 64'h0, 64'h55, 1'b0);
    re1 = 1'b1; raddr2 = 5'd8;
    expect_now("indep_ports", 64'h55, 64'h88, 1'b0);

    // Reset across an edge with a pending write: write lost, array cleared.
    @(negedge clk);
    wb_wreg = 1'b1; wb_wd = 5'd12; wb_wdata = 64'hABC;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    wb_wreg = 1'b0;
    raddr1 = 5'd12; raddr2 = 5'd3;
    expect_now("rst_mid_op", 64'h0, 64'h0, 1'b0);

    #5;
    total++;
    if (exp_q.size() != 0 || popped == 0) begin
      bad++;
      $display("FAIL scoreboard_drain: left %0d popped %0d", exp_q.size(), popped);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
